data_mem_responder: RTL

Responder (memory-side) end of the core's data memory port: accepts req/gnt transactions from the core's memory stage, performs byte, half and word stores into an internal word-organised RAM, and returns load data with a valid strobe. It sits between the core's `data_*` port and the data RAM in the SoC top, with a configurable number of wait states so the bench can model slow memory.

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Purpose : memory-side responder for the core's data port, backed by a word-organised RAM
//           with byte/half/word stores and right-aligned loads.
// Latency : grant WAIT_CYCLES+1 cycles after the request is seen, load response one cycle after grant.
// Backpressure: the core holds req and its fields until gnt; an early req drop during wait aborts.
// Ports   : clk/rst (sync, active-high); data_req_i/addr/wr/wdata/write_transfer from the core;
//           data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o back to the core (all registered).
module data_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 2,
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_CYCLES    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_addr_i,
  input  logic                      data_wr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] data_write_transfer_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      data_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, GNT, RESP} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  gnt_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic [1:0]            size;
  logic                  misaligned;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_data_d;
  logic                  mem_we;

  // Upper address bits are deliberately ignored: the RAM aliases.
  logic unused_addr;
  assign unused_addr = ^data_addr_i[ADDR_WIDTH-1:2+IDX_W];

  assign word_idx = data_addr_i[2 +: IDX_W];
  assign lane     = data_addr_i[1:0];
  assign size     = data_write_transfer_i[1:0];

  // Size code 11 is reserved and behaves exactly like a word access.
  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wr_data_d  = data_wdata_i;
    case (size)
      2'b00: begin
        be_d      = 4'b0001 << lane;
        wr_data_d = {4{data_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        be_d       = lane[1] ? 4'b1100 : 4'b0011;
        wr_data_d  = {2{data_wdata_i[15:0]}};
      end
      default: begin
        misaligned = (lane != 2'b00);
      end
    endcase
  end

  // Right-align the addressed lane and clear the lanes above the access size.
  always_comb begin
    rd_shift    = mem[word_idx] >> {lane, 3'b000};
    load_data_d = rd_shift;
    case (size)
      2'b00:   load_data_d = {24'd0, rd_shift[7:0]};
      2'b01:   load_data_d = {16'd0, rd_shift[15:0]};
      default: load_data_d = rd_shift;
    endcase
    if (misaligned) load_data_d = '0;
  end

  // A reset coinciding with the GNT edge suppresses the write.
  assign mem_we = (state_q == GNT) && data_wr_i && !misaligned && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[word_idx][8*b +: 8] <= wr_data_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        // RESP accepts a posted request exactly like IDLE does.
        IDLE, RESP: begin
          if (data_req_i) begin
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q <= GNT;
              gnt_q   <= 1'b1;
              err_q   <= data_wr_i && misaligned;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (!data_req_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= GNT;
            gnt_q   <= 1'b1;
            // Store errors are reported alongside the grant.
            err_q   <= data_wr_i && misaligned;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        GNT: begin
          if (data_wr_i) begin
            state_q <= IDLE;
          end else begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= load_data_d;
            err_q    <= misaligned;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_gnt_o    = gnt_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule
